mold_rerequest_tx: RTL and testbench
====================================

Name: mold_rerequest_tx

Overview:
- Transmit-side framer that builds a complete Ethernet/IPv4/UDP/MoldUDP64 retransmission-request frame from one request and streams it bytewise to the MAC TX path.
- It is the outbound counterpart of the receive parser. When the parser flags a lost packet, upstream logic issues a request (session, sequence, count), and this block emits the 62-byte frame.
- The MAC adds the preamble, FCS and padding. No payload buffering is needed because every field is latched at request acceptance.

Parameters:
- SRC_MAC, 48'h02_00_00_00_00_01, our MAC (Ethernet source).
- DST_MAC, 48'h02_00_00_00_00_02, rerequest server MAC.
- SRC_IP, 32'h0A00_0002, our IPv4 address.
- DST_IP, 32'h0A00_0001, rerequest server IPv4 address.
- SRC_PORT, 16'd30000, UDP source port.
- DST_PORT, 16'd30001, UDP destination port (rerequest server).
- TTL, 8'd64, IPv4 TTL.

Ports:
- clkIn  in  1  clock; single domain.
- rstIn  in  1  synchronous, active-high reset.
- reqValidIn  in  1  request present.
- reqReadyOut  out  1  block idle and able to accept a request.
- reqSessIdIn  in  80  MoldUDP64 session (10 ASCII bytes, MSB first).
- reqSeqNumIn  in  64  first missing sequence number.
- reqCountIn  in  16  number of messages requested.
- txDataOut  out  8  frame byte.
- txValidOut  out  1  txDataOut valid.
- txReadyIn  in  1  MAC accepts byte.
- txLastOut  out  1  marks final frame byte (index 61).
- busyOut  out  1  high from request acceptance until the last byte handshake.

Behaviour:
- Reset values:
  - reqReadyOut=1, txValidOut=0, txLastOut=0, busyOut=0, txDataOut=0.
  - IP ID counter = 0, state = IDLE.
  - Reset asserted mid-frame aborts the frame. The outputs above hold their reset values from the next cycle, and the latched request is discarded.
- State machine: IDLE -> CSUM_ADD -> CSUM_FOLD -> SEND -> IDLE.
  - IDLE: reqReadyOut=1. Acceptance occurs when reqValidIn & reqReadyOut at a rising edge. At acceptance, latch the session, sequence and count fields and go to CSUM_ADD.
  - CSUM_ADD (1 cycle): form a 20-bit sum of the IPv4 header 16-bit words, with the checksum field taken as 0.
  - CSUM_FOLD (1 cycle): fold the carries twice (sum[15:0]+sum[19:16], then again) and invert. Register the result as the checksum.
  - SEND: txValidOut=1 and byte index 0..61. The index advances only on txValidOut & txReadyIn. On the handshake of index 61, go to IDLE, increment the ID counter (16-bit, wraps 0xFFFF->0) and deassert busyOut.
  - reqReadyOut=0 in all states except IDLE. Requests are never queued.
- Latency: the first txValidOut is asserted in the 3rd cycle after the acceptance edge. With txReadyIn held high, the frame occupies 62 consecutive cycles.
- Handshake: txDataOut and txLastOut stay stable while txValidOut & !txReadyIn. txValidOut never drops mid-frame.
- Frame layout by byte index (all fields big-endian):
  - 0-5 DST_MAC; 6-11 SRC_MAC; 12-13 0x0800.
  - 14 0x45; 15 0x00; 16-17 total length 0x0030 (48).
  - 18-19 ID counter; 20-21 0x4000 (DF); 22 TTL; 23 0x11.
  - 24-25 checksum; 26-29 SRC_IP; 30-33 DST_IP.
  - 34-35 SRC_PORT; 36-37 DST_PORT; 38-39 UDP length 0x001C (28); 40-41 UDP checksum 0x0000.
  - 42-51 session; 52-59 sequence number; 60-61 count.
- Checksum words: 0x4500, 0x0030, ID, 0x4000, {TTL,0x11}, SRC_IP[31:16], SRC_IP[15:0], DST_IP[31:16], DST_IP[15:0].
- The ID used in the checksum and at bytes 18-19 is the value of the counter at acceptance.
- A reqValidIn change during SEND has no effect. Request fields may change after acceptance without affecting the frame.

Test Plan:
- Defaults, ID=0, session "TESTSESS01", seq 0x0000_0000_0000_1234, count 5, txReadyIn=1:
  - 62 bytes on consecutive cycles, first byte 3 cycles after acceptance.
  - Bytes 24-25 = 0x26BB, 52-59 = 00..12 34, 60-61 = 00 05, txLastOut only on byte 61.
- Second frame back-to-back: ID=1 at bytes 18-19 and checksum 0x26BA. reqReadyOut is low throughout the first frame and high in the cycle after byte 61 is accepted.
- Checksum carry: preload the counter to ID=0x3000 by sending frames or forcing it. Required checksum 0xF6BA.
- ID wrap: after a frame with ID=0xFFFF, the next frame carries ID=0x0000 and checksum 0x26BB.
- Backpressure: txReadyIn random 50% duty. The byte sequence is identical to the no-stall case, with no duplicate or dropped bytes, and txDataOut is stable during each stall.
- Reset at byte index 30:
  - txValidOut=0, busyOut=0 and reqReadyOut=1 on the next cycle.
  - The next request produces a full frame starting at index 0 with ID=0.

Source files
------------

// File: rtl/mold_rerequest_tx.sv
// rtl/mold_rerequest_tx.sv - builds and streams a 62-byte MoldUDP64 retransmission-request frame
// Request fields are latched at acceptance, so the frame needs no payload buffer.
module mold_rerequest_tx #(
  parameter logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC  = 48'h02_00_00_00_00_02,
  parameter logic [31:0] SRC_IP   = 32'h0A00_0002,
  parameter logic [31:0] DST_IP   = 32'h0A00_0001,
  parameter logic [15:0] SRC_PORT = 16'd30000,
  parameter logic [15:0] DST_PORT = 16'd30001,
  parameter logic [7:0]  TTL      = 8'd64
) (
  input  logic        clkIn,
  input  logic        rstIn,
  input  logic        reqValidIn,
  output logic        reqReadyOut,
  input  logic [79:0] reqSessIdIn,
  input  logic [63:0] reqSeqNumIn,
  input  logic [15:0] reqCountIn,
  output logic [7:0]  txDataOut,
  output logic        txValidOut,
  input  logic        txReadyIn,
  output logic        txLastOut,
  output logic        busyOut
);

  localparam logic [5:0] LAST_IDX = 6'd61;

  typedef enum logic [1:0] {IDLE, CSUM_ADD, CSUM_FOLD, SEND} stateT;

  stateT       state, stateNext;
  logic [79:0] sessId;
  logic [63:0] seqNum;
  logic [15:0] msgCount;
  logic [15:0] idCnt;
  logic [15:0] csum;
  logic [19:0] sum;
  logic [5:0]  byteIdx;
  logic        accept, txFire, lastFire;
  logic [19:0] sumNext;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [8:0]  bitOfs;
  logic [495:0] frame;

  assign accept   = reqValidIn && reqReadyOut;
  assign txFire   = (state == SEND) && txReadyIn;
  assign lastFire = txFire && (byteIdx == LAST_IDX);

  // idCnt only moves at the end of a frame, so it still holds the acceptance-time ID here
  assign sumNext = 20'(16'h4500) + 20'(16'h0030) + 20'(idCnt) + 20'(16'h4000)
                 + 20'({TTL, 8'h11}) + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
                 + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);
  assign fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
  assign fold2 = fold1[15:0] + 16'(fold1[16]);

  always_comb begin
    stateNext   = state;
    reqReadyOut = 1'b0;
    txValidOut  = 1'b0;
    busyOut     = 1'b1;
    case (state)
      IDLE: begin
        reqReadyOut = 1'b1;
        busyOut     = 1'b0;
        if (reqValidIn) stateNext = CSUM_ADD;
      end
      CSUM_ADD:  stateNext = CSUM_FOLD;
      CSUM_FOLD: stateNext = SEND;
      SEND: begin
        txValidOut = 1'b1;
        if (lastFire) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state    <= IDLE;
      sessId   <= '0;
      seqNum   <= '0;
      msgCount <= '0;
      idCnt    <= '0;
      csum     <= '0;
      sum      <= '0;
      byteIdx  <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        sessId   <= reqSessIdIn;
        seqNum   <= reqSeqNumIn;
        msgCount <= reqCountIn;
      end
      if (state == CSUM_ADD)  sum  <= sumNext;
      if (state == CSUM_FOLD) csum <= ~fold2;
      if (txFire) begin
        if (byteIdx == LAST_IDX) begin
          byteIdx <= '0;
          idCnt   <= idCnt + 16'd1;
        end else begin
          byteIdx <= byteIdx + 6'd1;
        end
      end
    end
  end

  // Byte 0 sits in the top bits of frame
  assign frame = {DST_MAC, SRC_MAC, 16'h0800,
                  8'h45, 8'h00, 16'h0030, idCnt, 16'h4000, TTL, 8'h11, csum,
                  SRC_IP, DST_IP,
                  SRC_PORT, DST_PORT, 16'h001C, 16'h0000,
                  sessId, seqNum, msgCount};

  assign bitOfs    = {LAST_IDX - byteIdx, 3'b000};
  assign txDataOut = (state == SEND) ? frame[bitOfs +: 8] : 8'h00;
  assign txLastOut = (state == SEND) && (byteIdx == LAST_IDX);

endmodule

// File: tb/tb_mold_rerequest_tx.sv
// tb/tb_mold_rerequest_tx.sv - directed self-checking bench for mold_rerequest_tx
module tb_mold_rerequest_tx;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b1;
  logic        reqValidIn = 1'b0;
  logic        reqReadyOut;
  logic [79:0] reqSessIdIn = '0;
  logic [63:0] reqSeqNumIn = '0;
  logic [15:0] reqCountIn = '0;
  logic [7:0]  txDataOut;
  logic        txValidOut;
  logic        txReadyIn = 1'b1;
  logic        txLastOut;
  logic        busyOut;

  int checks = 0;
  int fails = 0;

  logic [7:0] got[62];
  logic       gotLast[62];
  int         nGot, firstCyc, lastCyc, readyErrs, stallErrs, dropErrs;
  bit         timedOut;
  logic       accReady;
  int         badIdx;
  logic [7:0] badGot, badExp;

  always #5 clkIn = ~clkIn;

  mold_rerequest_tx dut (
    .clkIn(clkIn), .rstIn(rstIn),
    .reqValidIn(reqValidIn), .reqReadyOut(reqReadyOut),
    .reqSessIdIn(reqSessIdIn), .reqSeqNumIn(reqSeqNumIn), .reqCountIn(reqCountIn),
    .txDataOut(txDataOut), .txValidOut(txValidOut), .txReadyIn(txReadyIn),
    .txLastOut(txLastOut), .busyOut(busyOut)
  );

  function automatic logic [7:0] exp_byte(input int i, input logic [15:0] id, input logic [15:0] cs,
                                          input logic [79:0] s, input logic [63:0] q, input logic [15:0] c);
    logic [47:0] dm, sm;
    logic [31:0] sip, dip;
    dm = 48'h02_00_00_00_00_02;
    sm = 48'h02_00_00_00_00_01;
    sip = 32'h0A00_0002;
    dip = 32'h0A00_0001;
    if (i < 6)  return dm[8*(5-i) +: 8];
    if (i < 12) return sm[8*(11-i) +: 8];
    case (i)
      12: return 8'h08;  13: return 8'h00;  14: return 8'h45;  15: return 8'h00;
      16: return 8'h00;  17: return 8'h30;  18: return id[15:8]; 19: return id[7:0];
      20: return 8'h40;  21: return 8'h00;  22: return 8'h40;  23: return 8'h11;
      24: return cs[15:8]; 25: return cs[7:0];
      34: return 8'h75;  35: return 8'h30;  36: return 8'h75;  37: return 8'h31;
      38: return 8'h00;  39: return 8'h1C;  40: return 8'h00;  41: return 8'h00;
      60: return c[15:8]; 61: return c[7:0];
      default: ;
    endcase
    if (i < 30) return sip[8*(29-i) +: 8];
    if (i < 34) return dip[8*(33-i) +: 8];
    if (i < 52) return s[8*(51-i) +: 8];
    return q[8*(59-i) +: 8];
  endfunction

  // Counts byte/last mismatches in got[0..n-1]; remembers the first one for the FAIL line
  function automatic int frame_diffs(input int n, input logic [15:0] id, input logic [15:0] cs,
                                     input logic [79:0] s, input logic [63:0] q, input logic [15:0] c);
    int d;
    logic [7:0] e;
    d = 0;
    badIdx = -1;
    for (int i = 0; i < n; i++) begin
      e = exp_byte(i, id, cs, s, q, c);
      if (got[i] !== e || gotLast[i] !== (i == 61)) begin
        if (badIdx < 0) begin badIdx = i; badGot = got[i]; badExp = e; end
        d++;
      end
    end
    return d;
  endfunction

  task automatic do_frame(input logic [79:0] s, input logic [63:0] q, input logic [15:0] c,
                          input bit stall, input int abortAt);
    bit held;
    logic [7:0] heldData;
    logic heldLast;
    nGot = 0; firstCyc = -1; lastCyc = -1; timedOut = 0;
    readyErrs = 0; stallErrs = 0; dropErrs = 0; held = 0;
    heldData = '0; heldLast = 0;
    @(negedge clkIn);
    reqSessIdIn = s; reqSeqNumIn = q; reqCountIn = c; reqValidIn = 1'b1; txReadyIn = 1'b1;
    accReady = reqReadyOut;
    for (int cyc = 1; cyc <= 600 && nGot < 62; cyc++) begin
      @(negedge clkIn);
      if (cyc == 1) begin
        reqValidIn = 1'b0; reqSessIdIn = ~s; reqSeqNumIn = ~q; reqCountIn = ~c;
      end else if (stall) begin
        reqValidIn = 1'($urandom_range(0, 1));
      end
      txReadyIn = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (reqReadyOut !== 1'b0 || busyOut !== 1'b1) readyErrs++;
      if (txValidOut === 1'b1) begin
        if (firstCyc < 0) firstCyc = cyc;
        if (held && (txDataOut !== heldData || txLastOut !== heldLast)) stallErrs++;
        if (abortAt >= 0 && nGot == abortAt) break;
        if (txReadyIn) begin
          got[nGot] = txDataOut; gotLast[nGot] = txLastOut;
          nGot++; lastCyc = cyc; held = 0;
        end else begin
          held = 1; heldData = txDataOut; heldLast = txLastOut;
        end
      end else if (firstCyc >= 0) begin
        dropErrs++;
      end
      if (nGot == 62) reqValidIn = 1'b0;
    end
    reqValidIn = 1'b0;
    if (abortAt < 0 && nGot < 62) timedOut = 1;
  endtask

  task automatic test_reset();
    rstIn = 1'b1;
    repeat (2) @(posedge clkIn);
    @(negedge clkIn);
    checks++; if (reqReadyOut !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", reqReadyOut); end
    checks++; if (txValidOut !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", txValidOut); end
    checks++; if (txLastOut !== 1'b0) begin fails++; $display("FAIL reset_last: got %b want 0", txLastOut); end
    checks++; if (busyOut !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busyOut); end
    checks++; if (txDataOut !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", txDataOut); end
    rstIn = 1'b0;
  endtask

  task automatic test_basic();
    int d;
    do_frame("TESTSESS01", 64'h0000_0000_0000_1234, 16'd5, 0, -1);
    checks++; if (accReady !== 1'b1 || timedOut) begin fails++; $display("FAIL basic_accept: ready %b timeout %0d want 1/0", accReady, timedOut); end
    checks++; if (firstCyc !== 3) begin fails++; $display("FAIL basic_latency: got %0d want 3", firstCyc); end
    checks++; if (lastCyc - firstCyc !== 61) begin fails++; $display("FAIL basic_span: got %0d want 61", lastCyc - firstCyc); end
    checks++; if (readyErrs !== 0) begin fails++; $display("FAIL basic_ready_low: got %0d bad cycles want 0", readyErrs); end
    checks++; if ({got[24], got[25]} !== 16'h26BB) begin fails++; $display("FAIL basic_csum: got %h%h want 26bb", got[24], got[25]); end
    checks++; if ({got[60], got[61]} !== 16'h0005) begin fails++; $display("FAIL basic_count: got %h%h want 0005", got[60], got[61]); end
    d = frame_diffs(62, 16'h0000, 16'h26BB, "TESTSESS01", 64'h1234, 16'd5);
    checks++; if (d !== 0) begin fails++; $display("FAIL basic_bytes: %0d bad, idx %0d got %h want %h", d, badIdx, badGot, badExp); end
    @(negedge clkIn);
    checks++; if (reqReadyOut !== 1'b1 || busyOut !== 1'b0 || txValidOut !== 1'b0) begin
      fails++; $display("FAIL basic_after: ready %b busy %b valid %b want 1 0 0", reqReadyOut, busyOut, txValidOut); end
  endtask

  task automatic test_back_to_back();
    int d;
    do_frame("TESTSESS01", 64'h0000_0000_0000_1239, 16'd2, 0, -1);
    checks++; if ({got[18], got[19]} !== 16'h0001) begin fails++; $display("FAIL b2b_id: got %h%h want 0001", got[18], got[19]); end
    checks++; if ({got[24], got[25]} !== 16'h26BA) begin fails++; $display("FAIL b2b_csum: got %h%h want 26ba", got[24], got[25]); end
    d = frame_diffs(62, 16'h0001, 16'h26BA, "TESTSESS01", 64'h1239, 16'd2);
    checks++; if (d !== 0 || nGot !== 62 || readyErrs !== 0) begin
      fails++; $display("FAIL b2b_bytes: %0d bad n=%0d rdy=%0d, idx %0d got %h want %h", d, nGot, readyErrs, badIdx, badGot, badExp); end
    @(negedge clkIn);
    checks++; if (reqReadyOut !== 1'b1) begin fails++; $display("FAIL b2b_ready_after: got %b want 1", reqReadyOut); end
  endtask

  task automatic test_checksum_carry();
    int d;
    @(negedge clkIn);
    force dut.idCnt = 16'h3000;
    #1 release dut.idCnt;
    do_frame("CARRYTEST1", 64'h0102_0304_0506_0708, 16'h0100, 0, -1);
    checks++; if ({got[24], got[25]} !== 16'hF6BA) begin fails++; $display("FAIL carry_csum: got %h%h want f6ba", got[24], got[25]); end
    d = frame_diffs(62, 16'h3000, 16'hF6BA, "CARRYTEST1", 64'h0102_0304_0506_0708, 16'h0100);
    checks++; if (d !== 0 || nGot !== 62) begin fails++; $display("FAIL carry_bytes: %0d bad n=%0d, idx %0d got %h want %h", d, nGot, badIdx, badGot, badExp); end
    @(negedge clkIn);
  endtask

  task automatic test_id_wrap();
    int d;
    @(negedge clkIn);
    force dut.idCnt = 16'hFFFF;
    #1 release dut.idCnt;
    do_frame("WRAPWRAP00", 64'hFFFF_FFFF_FFFF_FFFF, 16'h1234, 0, -1);
    d = frame_diffs(62, 16'hFFFF, 16'h26BB, "WRAPWRAP00", 64'hFFFF_FFFF_FFFF_FFFF, 16'h1234);
    checks++; if (d !== 0 || nGot !== 62) begin fails++; $display("FAIL wrap_ffff_bytes: %0d bad n=%0d, idx %0d got %h want %h", d, nGot, badIdx, badGot, badExp); end
    @(negedge clkIn);
    do_frame("WRAPWRAP01", 64'h0, 16'h0001, 0, -1);
    checks++; if ({got[18], got[19], got[24], got[25]} !== 32'h0000_26BB) begin
      fails++; $display("FAIL wrap_zero_id_csum: got %h%h %h%h want 0000 26bb", got[18], got[19], got[24], got[25]); end
    @(negedge clkIn);
  endtask

  task automatic test_backpressure();
    int d;
    do_frame("ABCDEFGHIJ", 64'hFEDC_BA98_7654_3210, 16'hFFFF, 1, -1);
    checks++; if (timedOut || nGot !== 62) begin fails++; $display("FAIL bp_count: got %0d bytes timeout %0d want 62/0", nGot, timedOut); end
    checks++; if (stallErrs !== 0 || dropErrs !== 0) begin fails++; $display("FAIL bp_stable: unstable %0d dropped %0d want 0/0", stallErrs, dropErrs); end
    d = frame_diffs(62, 16'h0001, 16'h26BA, "ABCDEFGHIJ", 64'hFEDC_BA98_7654_3210, 16'hFFFF);
    checks++; if (d !== 0) begin fails++; $display("FAIL bp_bytes: %0d bad, idx %0d got %h want %h", d, badIdx, badGot, badExp); end
    checks++; if (readyErrs !== 0) begin fails++; $display("FAIL bp_ready_low: got %0d bad cycles want 0", readyErrs); end
    @(negedge clkIn);
  endtask

  task automatic test_mid_reset();
    int d;
    do_frame("ABORTABORT", 64'h1111_2222_3333_4444, 16'h0042, 0, 30);
    d = frame_diffs(30, 16'h0002, 16'h26B9, "ABORTABORT", 64'h1111_2222_3333_4444, 16'h0042);
    checks++; if (d !== 0 || nGot !== 30) begin fails++; $display("FAIL abort_prefix: %0d bad n=%0d, idx %0d got %h want %h", d, nGot, badIdx, badGot, badExp); end
    rstIn = 1'b1;
    @(negedge clkIn);
    checks++; if (txValidOut !== 1'b0 || busyOut !== 1'b0 || reqReadyOut !== 1'b1) begin
      fails++; $display("FAIL abort_outputs: valid %b busy %b ready %b want 0 0 1", txValidOut, busyOut, reqReadyOut); end
    rstIn = 1'b0;
    do_frame("AFTERRESET", 64'h0000_0000_0000_0077, 16'h0003, 0, -1);
    d = frame_diffs(62, 16'h0000, 16'h26BB, "AFTERRESET", 64'h77, 16'h0003);
    checks++; if (d !== 0 || nGot !== 62 || firstCyc !== 3) begin
      fails++; $display("FAIL abort_next_frame: %0d bad n=%0d first=%0d, idx %0d got %h want %h", d, nGot, firstCyc, badIdx, badGot, badExp); end
    @(negedge clkIn);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_checksum_carry();
    test_id_wrap();
    test_backpressure();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
